// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and tag layout for the FFT frame sequencer.
// No ports; imported by fft_tag_delay and fft_frame_sequencer.
package fft_pkg;
  localparam int NBITS = 10;
  localparam int N     = 128;
  localparam int BEATS = N / 4;
  localparam int LAT   = 40;
  localparam int FCW   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int TAG_W = 3;
  localparam int TAG_V = 2;
  localparam int TAG_S = 1;
  localparam int TAG_E = 0;
endpackage

// File: rtl/fft_tag_delay.sv
// DEPTH-stage {valid,sof,eof} delay line; empty_o when no stage holds valid.
// Ports: clk, rst (sync, active-low), tag_i, tag_o, empty_o.
module fft_tag_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             empty_o
);
  logic [DEPTH-1:0][TAG_W-1:0] sr_q;
  logic any_v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_v = any_v | sr_q[i][TAG_V];
    end
  end

  assign tag_o   = sr_q[DEPTH-1];
  assign empty_o = !any_v;
endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: feeds N/4-beat frames to the FFT lanes and tags its output.
// Ports: start/stop/cfg_nframes control, in_* stream, fft_in_* lanes, out_* tags, status.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int NBITS = fft_pkg::NBITS,
  parameter int N     = fft_pkg::N,
  parameter int LAT   = fft_pkg::LAT,
  parameter int FCW   = fft_pkg::FCW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [FCW-1:0]     cfg_nframes,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*NBITS-1:0] in_data,
  output logic [2*NBITS-1:0] fft_in0_up,
  output logic [2*NBITS-1:0] fft_in0_down,
  output logic [2*NBITS-1:0] fft_in1_up,
  output logic [2*NBITS-1:0] fft_in1_down,
  output logic               out_valid,
  output logic               out_sof,
  output logic               out_eof,
  output logic               busy,
  output logic               done,
  output logic               underrun,
  output logic [FCW-1:0]     frames_out
);
  localparam int BEAT_W = $clog2(N / 4);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N / 4 - 1);
  localparam int DW = 8 * NBITS;
  localparam int LW = 2 * NBITS;

  state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [FCW-1:0] iss_q, iss_d;
  logic [FCW-1:0] tgt_q, tgt_d;
  logic [FCW-1:0] fo_q, fo_d;
  logic stp_q, stp_d;
  logic und_q, und_d;
  logic [DW-1:0] lane_q, lane_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_out;
  logic sr_empty, empty;

  // tag_q sits alongside lane_q, so the delay line adds exactly LAT.
  fft_tag_delay #(.DEPTH(LAT)) u_dly (
    .clk     (clk),
    .rst     (rst),
    .tag_i   (tag_q),
    .tag_o   (tag_out),
    .empty_o (sr_empty)
  );

  assign empty = sr_empty && !tag_q[TAG_V];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    iss_d   = iss_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    und_d   = und_q;
    lane_d  = '0;
    tag_d   = '0;
    fo_d    = fo_q;
    if (tag_out[TAG_E] && fo_q != '1) begin
      fo_d = fo_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          und_d   = 1'b0;
          fo_d    = '0;
          tgt_d   = cfg_nframes;
          iss_d   = '0;
          beat_d  = '0;
          stp_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          stp_d = 1'b1;
        end
        // Frames open only on real data; once open, gaps are zero-filled.
        if (in_valid || beat_q != '0) begin
          lane_d       = in_valid ? in_data : '0;
          und_d        = und_q | !in_valid;
          tag_d[TAG_V] = 1'b1;
          tag_d[TAG_S] = (beat_q == '0);
          tag_d[TAG_E] = (beat_q == LAST_BEAT);
          beat_d       = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            iss_d = iss_q + FCW'(1);
            if ((tgt_q != '0 && iss_d == tgt_q) || stp_d) begin
              state_d = DRAIN;
            end
          end
        end else if (stp_d) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      iss_q   <= '0;
      tgt_q   <= '0;
      fo_q    <= '0;
      stp_q   <= 1'b0;
      und_q   <= 1'b0;
      lane_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      iss_q   <= iss_d;
      tgt_q   <= tgt_d;
      fo_q    <= fo_d;
      stp_q   <= stp_d;
      und_q   <= und_d;
      lane_q  <= lane_d;
      tag_q   <= tag_d;
    end
  end

  assign fft_in0_up   = lane_q[DW-1 -: LW];
  assign fft_in0_down = lane_q[DW-LW-1 -: LW];
  assign fft_in1_up   = lane_q[DW-2*LW-1 -: LW];
  assign fft_in1_down = lane_q[LW-1:0];
  assign out_valid    = tag_out[TAG_V];
  assign out_sof      = tag_out[TAG_S];
  assign out_eof      = tag_out[TAG_E];
  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DRAIN) && empty;
  assign underrun     = und_q;
  assign frames_out   = fo_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer.
// Lane and tag expectations are queued at drive time and popped at output.
module tb_fft_frame_sequencer;
  localparam int LAT = 40;
  localparam int BEATS = 32;

  logic clk, rst, start, stop, in_valid, in_ready;
  logic [15:0] cfg_nframes;
  logic [79:0] in_data;
  logic [19:0] f0u, f0d, f1u, f1d;
  logic out_valid, out_sof, out_eof, busy, done, underrun;
  logic [15:0] frames_out;

  fft_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_nframes(cfg_nframes), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data),
    .fft_in0_up(f0u), .fft_in0_down(f0d),
    .fft_in1_up(f1u), .fft_in1_down(f1d),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .done(done), .underrun(underrun),
    .frames_out(frames_out)
  );

  typedef struct { int t; logic [79:0] d; } lexp_t;
  typedef struct { int t; logic s; logic e; } texp_t;
  lexp_t lq[$];
  texp_t tq[$];
  int total, bad, cyc, done_cnt, done_t, last_tag_t;
  bit mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit ev;
    if (done === 1'b1) begin
      done_cnt++;
      done_t = cyc;
    end
    if (mon_en) begin
      if (lq.size() > 0 && lq[0].t == cyc) begin
        total++;
        if ({f0u, f0d, f1u, f1d} !== lq[0].d) begin
          bad++;
          $display("FAIL lane t=%0d got %h want %h", cyc,
                   {f0u, f0d, f1u, f1d}, lq[0].d);
        end
        void'(lq.pop_front());
      end
      ev = (tq.size() > 0 && tq[0].t == cyc);
      total++;
      if (out_valid !== ev) begin
        bad++;
        $display("FAIL out_valid t=%0d got %b want %b", cyc, out_valid, ev);
      end
      if (ev) begin
        total++;
        if ({out_sof, out_eof} !== {tq[0].s, tq[0].e}) begin
          bad++;
          $display("FAIL sof_eof t=%0d got %b%b want %b%b", cyc,
                   out_sof, out_eof, tq[0].s, tq[0].e);
        end
        void'(tq.pop_front());
      end
    end
  end

  function automatic logic [79:0] mk(input int b);
    mk = {20'(b), 20'($urandom), 20'($urandom), 20'($urandom)};
  endfunction

  task automatic issue(input int b, input bit v, input logic [79:0] d,
                       input bit stp, input bit stt);
    lexp_t le;
    texp_t te;
    @(posedge clk); #2;
    in_valid = v; in_data = d; stop = stp; start = stt;
    le.t = cyc + 1;
    le.d = v ? d : 80'd0;
    lq.push_back(le);
    te.t = cyc + 1 + LAT;
    te.s = (b == 0);
    te.e = (b == BEATS - 1);
    tq.push_back(te);
    last_tag_t = te.t;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      in_valid = 1'b0; stop = 1'b0; start = 1'b0;
    end
  endtask

  task automatic do_start(input int nf);
    @(posedge clk); #2;
    cfg_nframes = 16'(nf); start = 1'b1; in_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({out_valid, out_sof, out_eof, busy, done, underrun, in_ready} !== 7'd0
        || frames_out !== 16'd0 || {f0u, f0d, f1u, f1d} !== 80'd0) begin
      bad++;
      $display("FAIL reset_outs got %b%b%b%b%b%b%b fo=%0d want all 0",
               out_valid, out_sof, out_eof, busy, done, underrun, in_ready,
               frames_out);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    do_start(1);
    for (int b = 0; b < BEATS; b++) issue(b, 1'b1, mk(b), 1'b0, 1'b0);
    idle(1);
    wait_done(d0);
    total++;
    if (done_cnt != d0 + 1 || done_t != last_tag_t + 1) begin
      bad++;
      $display("FAIL single_done got n=%0d t=%0d want n=%0d t=%0d",
               done_cnt - d0, done_t, 1, last_tag_t + 1);
    end
    total++;
    if (frames_out !== 16'd1 || underrun !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_status got fo=%0d un=%b busy=%b want 1 0 0",
               frames_out, underrun, busy);
    end
    total++;
    if (lq.size() != 0 || tq.size() != 0) begin
      bad++;
      $display("FAIL single_left got %0d/%0d want 0/0", lq.size(), tq.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    do_start(3);
    for (int k = 0; k < 3 * BEATS; k++)
      issue(k % BEATS, 1'b1, mk(k % BEATS), 1'b0, 1'b0);
    idle(1);
    wait_done(d0);
    total++;
    if (done_cnt != d0 + 1 || done_t != last_tag_t + 1) begin
      bad++;
      $display("FAIL b2b_done got n=%0d t=%0d want n=1 t=%0d",
               done_cnt - d0, done_t, last_tag_t + 1);
    end
    total++;
    if (frames_out !== 16'd3 || underrun !== 1'b0 || tq.size() != 0) begin
      bad++;
      $display("FAIL b2b_status got fo=%0d un=%b left=%0d want 3 0 0",
               frames_out, underrun, tq.size());
    end
  endtask

  task automatic test_underrun();
    int d0 = done_cnt;
    do_start(1);
    for (int b = 0; b < BEATS; b++)
      issue(b, !(b == 10 || b == 11), mk(b), 1'b0, 1'b0);
    idle(1);
    wait_done(d0);
    total++;
    if (done_cnt != d0 + 1 || done_t != last_tag_t + 1) begin
      bad++;
      $display("FAIL und_done got n=%0d t=%0d want n=1 t=%0d",
               done_cnt - d0, done_t, last_tag_t + 1);
    end
    total++;
    if (frames_out !== 16'd1 || underrun !== 1'b1 || tq.size() != 0) begin
      bad++;
      $display("FAIL und_status got fo=%0d un=%b left=%0d want 1 1 0",
               frames_out, underrun, tq.size());
    end
  endtask

  task automatic test_stop();
    int d0 = done_cnt;
    do_start(0);
    for (int k = 0; k < 2 * BEATS; k++)
      issue(k % BEATS, 1'b1, mk(k % BEATS), (k == BEATS + 5), 1'b0);
    idle(1);
    wait_done(d0);
    total++;
    if (done_cnt != d0 + 1 || done_t != last_tag_t + 1) begin
      bad++;
      $display("FAIL stop_done got n=%0d t=%0d want n=1 t=%0d",
               done_cnt - d0, done_t, last_tag_t + 1);
    end
    total++;
    if (frames_out !== 16'd2 || busy !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL stop_status got fo=%0d busy=%b un=%b want 2 0 0",
               frames_out, busy, underrun);
    end
  endtask

  task automatic test_busy_start();
    int d0 = done_cnt;
    do_start(2);
    for (int k = 0; k < 2 * BEATS; k++)
      issue(k % BEATS, 1'b1, mk(k % BEATS), 1'b0, (k == 7));
    idle(5);
    @(posedge clk); #2; start = 1'b1;
    idle(1);
    wait_done(d0);
    total++;
    if (done_cnt != d0 + 1 || done_t != last_tag_t + 1) begin
      bad++;
      $display("FAIL bstart_done got n=%0d t=%0d want n=1 t=%0d",
               done_cnt - d0, done_t, last_tag_t + 1);
    end
    total++;
    if (frames_out !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bstart_status got fo=%0d busy=%b want 2 0",
               frames_out, busy);
    end
  endtask

  task automatic test_mid_reset();
    int d0 = done_cnt;
    do_start(1);
    for (int b = 0; b < 15; b++) issue(b, 1'b1, mk(b), 1'b0, 1'b0);
    @(posedge clk); #2;
    mon_en = 1'b0;
    lq.delete();
    tq.delete();
    rst = 1'b0; in_valid = 1'b1; in_data = mk(15);
    @(posedge clk); #2;
    total++;
    if ({out_valid, out_sof, out_eof, busy, done, underrun, in_ready} !== 7'd0
        || frames_out !== 16'd0 || {f0u, f0d, f1u, f1d} !== 80'd0) begin
      bad++;
      $display("FAIL midrst_outs got v%b b%b d%b r%b lane=%h want all 0",
               out_valid, busy, done, in_ready, {f0u, f0d, f1u, f1d});
    end
    rst = 1'b1; in_valid = 1'b0;
    mon_en = 1'b1;
    idle(LAT + 40);
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("FAIL midrst_nodone got %0d want 0", done_cnt - d0);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; done_cnt = 0; done_t = -1;
    mon_en = 1'b0; last_tag_t = 0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_data = '0; cfg_nframes = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_stop();
    test_busy_start();
    test_mid_reset();
    test_single();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Streaming front-end controller for the 4-sample-per-cycle parallel FFT datapath (topfft, N=128).
- Accepts input beats over a valid/ready handshake and drives the four datapath input lanes with contiguous frames of N/4 beats.
- Zero-fills any mid-frame underrun, then drains the pipeline.
- Tags the datapath output with valid/start-of-frame/end-of-frame markers, aligned to the datapath's fixed latency.

Parameters:
- NBITS, 10, real/imag width of each input sample (lane width 2*NBITS)
- N, 128, FFT points per frame; power of 2, >= 8
- LAT, 40, datapath latency in clk cycles from the first beat at fft_in_* to the first output beat at fftOut*; >= 1
- FCW, 16, width of the frame-count config and status

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge)
- start  in  1  single-cycle pulse; begins a run; ignored unless state is IDLE
- stop  in  1  single-cycle pulse; finish the current frame, then drain
- cfg_nframes  in  FCW  frames per run; 0 means continuous until stop
- in_valid  in  1  input beat present
- in_ready  out  1  sequencer accepts a beat this cycle
- in_data  in  8*NBITS  {in0_up, in0_down, in1_up, in1_down}, MSB first
- fft_in0_up, fft_in0_down, fft_in1_up, fft_in1_down  out  2*NBITS each  registered datapath inputs
- out_valid  out  1  datapath output beat is valid
- out_sof  out  1  first output beat of a frame
- out_eof  out  1  last output beat of a frame
- busy  out  1  state != IDLE
- done  out  1  single-cycle pulse when the last tagged output beat leaves
- underrun  out  1  sticky; set on any zero-filled beat; cleared by start or reset
- frames_out  out  FCW  count of completed output frames this run

Behaviour:
- BEATS = N/4 (32 by default). A beat counter of width log2(BEATS) wraps from BEATS-1 to 0.
- Reset (rst=0 at a clk edge):
  - all outputs go to 0 and fft_in_* to 0;
  - state goes to IDLE;
  - the tag shift register is cleared.
  - Reset mid-run abandons the run; no done pulse is issued.
- FSM states and transitions:
  - IDLE: in_ready=0. On start, clear underrun and frames_out, load the frame target, and go to RUN with beat=0.
  - RUN: in_ready=1, and a beat is issued every cycle.
    - If in_valid=1, register in_data onto fft_in_*.
    - If in_valid=0 and beat!=0, drive zeros and set underrun.
    - If in_valid=0 and beat==0, issue nothing: fft_in_* = 0, no tag, and the counter holds. Frames therefore start only on real data.
    - When beat==BEATS-1 is issued, increment the issued-frame count. Go to DRAIN if the count hits cfg_nframes (nonzero) or a stop is pending; otherwise stay in RUN.
  - DRAIN: in_ready=0; fft_in_* = 0. Wait until the tag shift register is empty, then pulse done and go to IDLE.
- stop while in RUN at beat==0 with no frame open: go to DRAIN directly. stop in IDLE or DRAIN: ignored.
- start and stop in the same cycle while in IDLE: start wins and stop is dropped.
- Tag path: a LAT-deep shift register of {valid, sof, eof}.
  - A tag is pushed each cycle a beat is issued; sof when beat==0, eof when beat==BEATS-1.
  - Its output drives out_valid/out_sof/out_eof directly (registered).
  - Hence out_valid rises exactly LAT cycles after the first issued beat.
- frames_out increments on the cycle out_eof=1. It saturates at 2^FCW-1.
- A zero-filled beat still carries valid=1 in its tag, so output frames are always BEATS contiguous beats.

Decomposition:
- Shared package fft_pkg:
  - NBITS, N, BEATS, LAT;
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2);
  - tag field indices.
- One sub-module, fft_tag_delay: a parameterized LAT-deep {valid,sof,eof} shift register with an "empty" output (OR of the valid bits). Everything else stays in fft_frame_sequencer.

Test Plan:
- Reset, then cfg_nframes=1, start, and 32 contiguous beats with in_data=beat index. Required response:
  - fft_in0_up carries the values in order;
  - out_valid high for exactly 32 cycles starting 40 cycles after the first beat;
  - out_sof on the 1st and out_eof on the 32nd of those cycles;
  - done 1 cycle after the last tag;
  - frames_out=1; underrun=0.
- cfg_nframes=3 with continuous data: 96 back-to-back output beats, and out_sof/out_eof at beats 0/31, 32/63 and 64/95. Also frames_out=3 and a single done.
- cfg_nframes=1 with in_valid dropped at beat 10 for 2 cycles: the beats issued in those 2 cycles are zero, underrun=1, and the frame completes with 32 tagged beats ending at beat 31.
- cfg_nframes=0 with stop pulsed at beat 5 of frame 2: frame 2 completes, frames_out=2, then done, and state returns to IDLE.
- rst=0 asserted for 1 cycle at beat 15 of a frame: all outputs are 0 the next cycle, and no done pulse ever appears. A subsequent start runs normally.
- start pulsed again while busy: ignored, with no change to the frame count or the timing of done.
